// File: rtl/disp_reg_mirror_if.sv
// Register-file write snoop bus: strobe, destination index and data.
interface disp_reg_mirror_if;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;

    modport master (output we, output waddr, output wdata);
    modport slave  (input  we, input  waddr, input  wdata);
endinterface

// File: rtl/disp_reg_mirror.sv
// Shadow copies of eight register-file entries for the seven-segment display,
// with a freeze mode that buffers writes, plus the display scan-clock prescaler.
module disp_reg_mirror #(
    parameter int unsigned DIV = 25000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    disp_reg_mirror_if.slave         wr,
    input  logic                     freeze,
    input  logic                     clr,
    output logic [15:0]              reg_0,
    output logic [15:0]              reg_1,
    output logic [15:0]              reg_2,
    output logic [15:0]              reg_3,
    output logic [15:0]              reg_4,
    output logic [15:0]              reg_5,
    output logic [15:0]              reg_6,
    output logic [15:0]              reg_7,
    output logic [7:0]               pending,
    output logic                     sl_clk
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    logic [15:0]     r_shadow [8];
    logic [15:0]     r_pend   [8];
    logic [7:0]      r_pending;
    logic [CntW-1:0] r_cnt;
    logic            r_sl_clk;

    // Shadow/pending update: clear beats freeze buffering beats live write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 8; n++) begin
                r_shadow[n] <= 16'h0000;
                r_pend[n]   <= 16'h0000;
            end
            r_pending <= 8'h00;
        end else if (clr) begin
            for (int n = 0; n < 8; n++) begin
                r_shadow[n] <= 16'h0000;
                r_pend[n]   <= 16'h0000;
            end
            r_pending <= 8'h00;
        end else if (freeze) begin
            if (wr.we) begin
                r_pend[wr.waddr]    <= wr.wdata;
                r_pending[wr.waddr] <= 1'b1;
            end
        end else begin
            // Commit all buffered entries atomically; a live write issued
            // later in this block overrides a commit to the same register.
            for (int n = 0; n < 8; n++) begin
                if (r_pending[n]) begin
                    r_shadow[n] <= r_pend[n];
                end
            end
            if (wr.we) begin
                r_shadow[wr.waddr] <= wr.wdata;
            end
            r_pending <= 8'h00;
        end
    end

    // Free-running prescaler; sl_clk toggles each time the count wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_sl_clk <= 1'b0;
        end else if (r_cnt == CntMax) begin
            r_cnt    <= '0;
            r_sl_clk <= ~r_sl_clk;
        end else begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

    assign reg_0   = r_shadow[0];
    assign reg_1   = r_shadow[1];
    assign reg_2   = r_shadow[2];
    assign reg_3   = r_shadow[3];
    assign reg_4   = r_shadow[4];
    assign reg_5   = r_shadow[5];
    assign reg_6   = r_shadow[6];
    assign reg_7   = r_shadow[7];
    assign pending = r_pending;
    assign sl_clk  = r_sl_clk;

endmodule

// File: tb/tb_disp_reg_mirror.sv
// Scoreboard bench for disp_reg_mirror: DIV=3 main instance, DIV=1 prescaler instance.
module tb_disp_reg_mirror;

    logic clk;
    logic rst_n;
    logic freeze;
    logic clr;

    disp_reg_mirror_if wr ();
    disp_reg_mirror_if wr_b ();

    logic [15:0] o_reg [8];
    logic [7:0]  o_pending;
    logic        o_sl_clk;

    logic [15:0] b_reg [8];
    logic [7:0]  b_pending;
    logic        b_sl_clk;

    assign wr_b.we    = 1'b0;
    assign wr_b.waddr = 3'd0;
    assign wr_b.wdata = 16'h0000;

    disp_reg_mirror #(.DIV(3)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr      (wr),
        .freeze  (freeze),
        .clr     (clr),
        .reg_0   (o_reg[0]),
        .reg_1   (o_reg[1]),
        .reg_2   (o_reg[2]),
        .reg_3   (o_reg[3]),
        .reg_4   (o_reg[4]),
        .reg_5   (o_reg[5]),
        .reg_6   (o_reg[6]),
        .reg_7   (o_reg[7]),
        .pending (o_pending),
        .sl_clk  (o_sl_clk)
    );

    disp_reg_mirror #(.DIV(1)) u_dut_div1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr      (wr_b),
        .freeze  (1'b0),
        .clr     (1'b0),
        .reg_0   (b_reg[0]),
        .reg_1   (b_reg[1]),
        .reg_2   (b_reg[2]),
        .reg_3   (b_reg[3]),
        .reg_4   (b_reg[4]),
        .reg_5   (b_reg[5]),
        .reg_6   (b_reg[6]),
        .reg_7   (b_reg[7]),
        .pending (b_pending),
        .sl_clk  (b_sl_clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0][15:0] regs;
        logic [7:0]       pend;
    } exp_t;

    exp_t        sb_q [$];
    logic [15:0] m_sh   [8];
    logic [15:0] m_buf  [8];
    logic [7:0]  m_pbit;
    int          edges;
    int          n_checks;
    int          n_errors;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 8; n++) begin
            m_sh[n]  = 16'h0000;
            m_buf[n] = 16'h0000;
        end
        m_pbit = 8'h00;
        edges  = 0;
    endtask

    // Drive one cycle, predict the post-edge state, then compare after the edge.
    task automatic drive_cycle(input logic i_we, input logic [2:0] i_a, input logic [15:0] i_d,
                               input logic i_frz, input logic i_clr);
        exp_t e;
        exp_t got;
        wr.we    = i_we;
        wr.waddr = i_a;
        wr.wdata = i_d;
        freeze   = i_frz;
        clr      = i_clr;
        if (i_clr) begin
            for (int n = 0; n < 8; n++) begin
                m_sh[n]  = 16'h0000;
                m_buf[n] = 16'h0000;
            end
            m_pbit = 8'h00;
        end else if (i_frz) begin
            if (i_we) begin
                m_buf[i_a]  = i_d;
                m_pbit[i_a] = 1'b1;
            end
        end else begin
            for (int n = 0; n < 8; n++) begin
                if (m_pbit[n]) m_sh[n] = m_buf[n];
            end
            if (i_we) m_sh[i_a] = i_d;
            m_pbit = 8'h00;
        end
        for (int n = 0; n < 8; n++) e.regs[n] = m_sh[n];
        e.pend = m_pbit;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        edges++;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            for (int n = 0; n < 8; n++) begin
                check_val($sformatf("reg_%0d", n), {16'h0, o_reg[n]}, {16'h0, got.regs[n]});
            end
            check_val("pending", {24'h0, o_pending}, {24'h0, got.pend});
        end
        check_val("sl_clk_div3", {31'h0, o_sl_clk}, 32'((edges / 3) % 2));
        check_val("sl_clk_div1", {31'h0, b_sl_clk}, 32'(edges % 2));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        freeze   = 1'b0;
        clr      = 1'b0;
        wr.we    = 1'b0;
        wr.waddr = 3'd0;
        wr.wdata = 16'h0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int n = 0; n < 8; n++) check_val($sformatf("rst_reg_%0d", n), {16'h0, o_reg[n]}, 32'h0);
        check_val("rst_pending", {24'h0, o_pending}, 32'h0);
        check_val("rst_sl_clk", {31'h0, o_sl_clk}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Live write
        drive_cycle(1'b1, 3'd3, 16'hBEEF, 1'b0, 1'b0);
        drive_cycle(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);

        // Freeze buffering, last write wins, commit on release
        drive_cycle(1'b1, 3'd5, 16'h1234, 1'b1, 1'b0);
        drive_cycle(1'b1, 3'd5, 16'h5678, 1'b1, 1'b0);
        drive_cycle(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0);
        drive_cycle(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);

        // Release collides with a live write to a pending register
        drive_cycle(1'b1, 3'd2, 16'hAAAA, 1'b1, 1'b0);
        drive_cycle(1'b1, 3'd6, 16'h6666, 1'b1, 1'b0);
        drive_cycle(1'b1, 3'd2, 16'h5555, 1'b0, 1'b0);

        // Fill all pending, then clear with a competing write
        for (int n = 0; n < 8; n++) drive_cycle(1'b1, 3'(n), 16'(16'h1111 * (n + 1)), 1'b1, 1'b0);
        drive_cycle(1'b1, 3'd0, 16'hFFFF, 1'b0, 1'b1);
        drive_cycle(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 24; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                        16'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0));
        end
        drive_cycle(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);

        // Reset mid-freeze discards pending data
        drive_cycle(1'b1, 3'd0, 16'hC0DE, 1'b1, 1'b0);
        drive_cycle(1'b1, 3'd7, 16'hF00D, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        for (int n = 0; n < 8; n++) check_val($sformatf("arst_reg_%0d", n), {16'h0, o_reg[n]}, 32'h0);
        check_val("arst_pending", {24'h0, o_pending}, 32'h0);
        check_val("arst_sl_clk", {31'h0, o_sl_clk}, 32'h0);
        check_val("arst_sl_clk_div1", {31'h0, b_sl_clk}, 32'h0);
        model_reset();
        wr.we  = 1'b0;
        freeze = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) drive_cycle(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
